// File: rtl/dr_fetch_pkg.sv
// Shared state encoding, data-register control codes and counter width
// for the data-register fetch sequencer.
package dr_fetch_pkg;

  // Wide enough to count up to four bytes.
  localparam int DR_CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } fetch_state_t;

  localparam logic [1:0] DR_FS_SEXT = 2'b00;
  localparam logic [1:0] DR_FS_ZEXT = 2'b01;
  localparam logic [1:0] DR_FS_SHL  = 2'b10;
  localparam logic [1:0] DR_FS_SHR  = 2'b11;

  function automatic logic [1:0] first_funsel(input logic is_signed);
    return is_signed ? DR_FS_SEXT : DR_FS_ZEXT;
  endfunction

endpackage

// File: rtl/dr_fetch_addr_gen.sv
// Read address counter (start, step, direction, modulo wrap) plus counters
// of bytes issued to memory and bytes returned to the data register.
module dr_fetch_addr_gen
  import dr_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
)
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic [ADDR_WIDTH-1:0] i_base,
  input  logic [1:0]            i_count,
  input  logic                  i_big_endian,
  input  logic                  i_step,
  input  logic                  i_issue,
  input  logic                  i_capture,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DR_CNT_W-1:0]   o_issued,
  output logic [DR_CNT_W-1:0]   o_returned
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  logic                  r_dir_up;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DR_CNT_W-1:0]   r_issued;
  logic [DR_CNT_W-1:0]   r_returned;
  logic [ADDR_WIDTH-1:0] w_first_addr;
  logic [ADDR_WIDTH-1:0] w_next_addr;

  // The most significant byte is fetched first: lowest address for big
  // endian, highest address for little endian. Arithmetic wraps naturally.
  assign w_first_addr = i_big_endian ? i_base : i_base + ADDR_WIDTH'(i_count);
  assign w_next_addr  = r_dir_up ? r_addr + ADDR_ONE : r_addr - ADDR_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dir_up   <= 1'b0;
      r_addr     <= '0;
      r_issued   <= '0;
      r_returned <= '0;
    end else if (i_load) begin
      r_dir_up   <= i_big_endian;
      r_addr     <= w_first_addr;
      r_issued   <= '0;
      r_returned <= '0;
    end else begin
      if (i_step) begin
        r_addr <= w_next_addr;
      end
      if (i_issue) begin
        r_issued <= r_issued + DR_CNT_W'(1);
      end
      if (i_capture) begin
        r_returned <= r_returned + DR_CNT_W'(1);
      end
    end
  end

  assign o_addr     = r_addr;
  assign o_issued   = r_issued;
  assign o_returned = r_returned;

endmodule

// File: rtl/dr_fetch_sequencer.sv
// Fills the 32-bit data register from byte-wide memory with 1..4 pipelined reads.
// Optional alignment check: define DR_FETCH_ALIGN_CHECK_EN.
module dr_fetch_sequencer
  import dr_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
)
(
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [ADDR_WIDTH-1:0] Addr,
  input  logic [1:0]            Count,
  input  logic                  BigEndian,
  input  logic                  Signed,
  input  logic [7:0]            MemData,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic                  MemRead,
  output logic [7:0]            DRData,
  output logic [1:0]            DRFunSel,
  output logic                  DREnable,
  output logic                  Busy,
  output logic                  Done,
  output logic                  AlignErr,
  output logic [1:0]            DbgState
);

  // Handshake: Start is a one-cycle request honoured only in IDLE or in the
  // Done cycle; MemData is valid the cycle after a MemRead edge; DRData and
  // DRFunSel are meaningful only while DREnable is high.

  fetch_state_t          r_state;
  logic [1:0]            r_count;
  logic                  r_signed;
  logic                  r_pend;
  logic                  w_accept;
  logic                  w_misalign;
  logic                  w_load;
  logic                  w_last;
  logic                  w_step;
  logic [DR_CNT_W-1:0]   w_issued;
  logic [DR_CNT_W-1:0]   w_returned;
  logic [ADDR_WIDTH-1:0] w_addr;

  assign w_accept = Start && (r_state == ST_IDLE || r_state == ST_FINISH);
  assign w_load   = w_accept && !w_misalign;
  assign w_last   = (w_issued == {1'b0, r_count});
  // The address holds after the final read rather than running ahead.
  assign w_step   = MemRead && !w_last;

  dr_fetch_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .clk          (Clock),
    .rst_n        (Reset),
    .i_load       (w_load),
    .i_base       (Addr),
    .i_count      (Count),
    .i_big_endian (BigEndian),
    .i_step       (w_step),
    .i_issue      (MemRead),
    .i_capture    (r_pend),
    .o_addr       (w_addr),
    .o_issued     (w_issued),
    .o_returned   (w_returned)
  );

  assign MemAddr  = w_addr;
  assign DbgState = r_state;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state  <= ST_IDLE;
      r_count  <= '0;
      r_signed <= 1'b0;
      r_pend   <= 1'b0;
      MemRead  <= 1'b0;
      DRData   <= '0;
      DRFunSel <= DR_FS_SEXT;
      DREnable <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
    end else begin
      // r_pend marks that MemData carries a byte this cycle.
      r_pend   <= MemRead;
      DREnable <= r_pend;
      if (r_pend) begin
        DRData   <= MemData;
        DRFunSel <= (w_returned == '0) ? first_funsel(r_signed) : DR_FS_SHL;
      end
      case (r_state)
        ST_IDLE, ST_FINISH: begin
          Done <= 1'b0;
          if (w_accept) begin
            r_count  <= Count;
            r_signed <= Signed;
            Busy     <= 1'b1;
            MemRead  <= !w_misalign;
            r_state  <= w_misalign ? ST_DRAIN : ST_ISSUE;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (w_last) begin
            MemRead <= 1'b0;
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Once no byte is in flight the last register write has happened.
          if (!r_pend) begin
            Busy    <= 1'b0;
            Done    <= 1'b1;
            r_state <= ST_FINISH;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef DR_FETCH_ALIGN_CHECK_EN
  logic r_misal;
  logic r_align_err;

  assign w_misalign = (Count == 2'd1 && Addr[0]) ||
                      (Count == 2'd3 && Addr[1:0] != 2'b00);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_misal     <= 1'b0;
      r_align_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_misal <= w_misalign;
      end
      r_align_err <= (r_state == ST_DRAIN) && !r_pend && r_misal;
    end
  end

  assign AlignErr = r_align_err;
`else
  assign w_misalign = 1'b0;
  assign AlignErr   = 1'b0;
`endif

endmodule

// File: tb/tb_dr_fetch_sequencer.sv
// Self-checking bench for dr_fetch_sequencer: directed cases plus random loads
// compared with a byte-assembly reference model.
module tb_dr_fetch_sequencer;

  localparam int AW = 16;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          Start;
  logic [AW-1:0] Addr;
  logic [1:0]    Count;
  logic          BigEndian;
  logic          Signed;
  logic [7:0]    MemData = 8'h00;
  logic [AW-1:0] MemAddr;
  logic          MemRead;
  logic [7:0]    DRData;
  logic [1:0]    DRFunSel;
  logic          DREnable;
  logic          Busy;
  logic          Done;
  logic          AlignErr;
  logic [1:0]    DbgState;

  logic [7:0]    mem [0:65535];
  logic [31:0]   dr_reg = 32'h0;
  logic [AW-1:0] rd_q[$];
  logic [1:0]    fs_q[$];
  int            n_cmp = 0;
  int            n_fail = 0;

  always #5 Clock = ~Clock;

  dr_fetch_sequencer #(.ADDR_WIDTH(AW)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Start     (Start),
    .Addr      (Addr),
    .Count     (Count),
    .BigEndian (BigEndian),
    .Signed    (Signed),
    .MemData   (MemData),
    .MemAddr   (MemAddr),
    .MemRead   (MemRead),
    .DRData    (DRData),
    .DRFunSel  (DRFunSel),
    .DREnable  (DREnable),
    .Busy      (Busy),
    .Done      (Done),
    .AlignErr  (AlignErr),
    .DbgState  (DbgState)
  );

  // Byte-wide memory and the data register it feeds.
  always @(posedge Clock) begin
    if (MemRead) begin
      MemData <= mem[MemAddr];
      rd_q.push_back(MemAddr);
    end
    if (DREnable) begin
      fs_q.push_back(DRFunSel);
      case (DRFunSel)
        2'b00: dr_reg <= {{24{DRData[7]}}, DRData};
        2'b01: dr_reg <= {24'h0, DRData};
        2'b10: dr_reg <= {dr_reg[23:0], DRData};
        default: dr_reg <= {8'h00, dr_reg[31:8]};
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Address of the j-th fetched byte (most significant first).
  function automatic logic [AW-1:0] ref_addr(input logic [AW-1:0] a, input int n,
                                             input logic be, input int j);
    return be ? a + AW'(j) : a + AW'(n - 1 - j);
  endfunction

  function automatic logic [31:0] ref_word(input logic [AW-1:0] a, input int n,
                                           input logic be, input logic sg);
    logic [31:0] v;
    logic        msb;
    v   = 32'h0;
    msb = mem[ref_addr(a, n, be, 0)][7];
    for (int j = 0; j < n; j++) begin
      v = (v << 8) | {24'h0, mem[ref_addr(a, n, be, j)]};
    end
    if (sg && msb && n < 4) begin
      v = v | (32'hFFFF_FFFF << (8 * n));
    end
    return v;
  endfunction

  task automatic run_load(input logic [AW-1:0] a, input logic [1:0] c, input logic be,
                          input logic sg, input bit poke, input bit settle);
    int n, e, rb, fb, busy_bad;
    bit seen;
    n  = int'(c) + 1;
    rb = rd_q.size();
    fb = fs_q.size();
    @(negedge Clock);
    Start = 1'b1; Addr = a; Count = c; BigEndian = be; Signed = sg;
    @(posedge Clock); #1;
    // Scramble request inputs to show they were latched.
    Start = 1'b0; Addr = AW'($urandom); Count = 2'($urandom);
    BigEndian = 1'($urandom); Signed = 1'($urandom);
    e = 0; seen = 0; busy_bad = 0;
    if (!Busy) busy_bad++;
    while (!seen && e < 16) begin
      if (poke && e == 1) begin
        Start = 1'b1; Addr = 16'h0100; Count = 2'd3;
      end
      if (poke && e == 2) Start = 1'b0;
      @(posedge Clock); #1;
      e++;
      if (Done) seen = 1;
      else if (!Busy) busy_bad++;
    end
    Start = 1'b0;
    chk("latency", e, n + 2);
    chk("busy_at_done", Busy, 0);
    chk("align_err", AlignErr, 0);
    chk("read_cycles", rd_q.size() - rb, n);
    for (int j = 0; j < n; j++) begin
      if (rb + j < rd_q.size()) chk("rd_addr", rd_q[rb + j], ref_addr(a, n, be, j));
    end
    chk("enables", fs_q.size() - fb, n);
    if (fs_q.size() > fb) chk("first_funsel", fs_q[fb], sg ? 2'b00 : 2'b01);
    for (int j = 1; j < n; j++) begin
      if (fb + j < fs_q.size()) chk("later_funsel", fs_q[fb + j], 2'b10);
    end
    chk("dr_word", dr_reg, ref_word(a, n, be, sg));
    chk("busy_during", busy_bad, 0);
    if (settle) begin
      @(posedge Clock); #1;
      chk("done_width", Done, 0);
      chk("idle_busy", Busy, 0);
      chk("idle_read", MemRead, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] ra;
    logic [1:0]    rc;
    int            ens, e, fb;

    Reset = 1'b0; Start = 1'b0; Addr = '0; Count = '0; BigEndian = 1'b0; Signed = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'h0010] = 8'h12; mem[16'h0011] = 8'h34; mem[16'h0012] = 8'h56; mem[16'h0013] = 8'h78;
    mem[16'h0020] = 8'h80;
    mem[16'hFFFF] = 8'hAB; mem[16'h0000] = 8'hCD;

    repeat (3) @(posedge Clock);
    #1;
    chk("reset_outputs", {MemAddr, MemRead, DRData, DRFunSel, DREnable, Busy, Done, AlignErr}, 0);
    @(negedge Clock);
    Reset = 1'b1;

    // Directed cases from the test plan.
    run_load(16'h0010, 2'd3, 1'b1, 1'b0, 0, 1);
    chk("be_word", dr_reg, 32'h1234_5678);
    run_load(16'h0010, 2'd3, 1'b0, 1'b0, 0, 1);
    chk("le_word", dr_reg, 32'h7856_3412);
    run_load(16'h0020, 2'd0, 1'b1, 1'b1, 0, 1);
    chk("sext_byte", dr_reg, 32'hFFFF_FF80);
    run_load(16'h0020, 2'd0, 1'b1, 1'b0, 0, 1);
    chk("zext_byte", dr_reg, 32'h0000_0080);
    run_load(16'hFFFF, 2'd1, 1'b1, 1'b0, 0, 1);
    chk("wrap_word", dr_reg, 32'h0000_ABCD);

    // Start while busy is ignored; back-to-back Start in the Done cycle.
    run_load(16'h0030, 2'd2, 1'b0, 1'b1, 1, 1);
    run_load(16'h0040, 2'd1, 1'b1, 1'b1, 0, 0);
    run_load(16'h0050, 2'd3, 1'b0, 1'b0, 0, 1);

    // Randomized loads.
    for (int t = 0; t < 24; t++) begin
      ra = AW'($urandom);
      rc = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) ra = 16'hFFFF - AW'($urandom_range(0, 2));
`ifdef DR_FETCH_ALIGN_CHECK_EN
      if (rc == 2'd1) ra[0] = 1'b0;
      if (rc == 2'd3) ra[1:0] = 2'b00;
`endif
      run_load(ra, rc, 1'($urandom), 1'($urandom), 0, ($urandom_range(0, 1) == 1));
    end

    // Reset during the second register write of a 4-byte load.
    @(negedge Clock);
    Start = 1'b1; Addr = 16'h0010; Count = 2'd3; BigEndian = 1'b1; Signed = 1'b0;
    @(posedge Clock); #1;
    Start = 1'b0;
    ens = 0; e = 0;
    while (ens < 2 && e < 12) begin
      @(posedge Clock); #1;
      e++;
      if (DREnable) ens++;
    end
    chk("rst_reach", ens, 2);
    #2 Reset = 1'b0;
    #1;
    chk("rst_mid_outputs", {MemAddr, MemRead, DRData, DRFunSel, DREnable, Busy, Done, AlignErr}, 0);
    fb = fs_q.size();
    @(negedge Clock);
    Reset = 1'b1;
    repeat (6) @(posedge Clock);
    #1;
    chk("rst_no_enable", fs_q.size() - fb, 0);
    chk("rst_idle", Busy, 0);
    run_load(16'h0010, 2'd3, 1'b1, 1'b1, 0, 1);

`ifdef DR_FETCH_ALIGN_CHECK_EN
    fb = rd_q.size();
    @(negedge Clock);
    Start = 1'b1; Addr = 16'h0002; Count = 2'd3; BigEndian = 1'b1; Signed = 1'b0;
    @(posedge Clock); #1;
    Start = 1'b0;
    chk("mis_busy", Busy, 1);
    chk("mis_noread", MemRead, 0);
    @(posedge Clock); #1;
    chk("mis_done", Done, 1);
    chk("mis_alignerr", AlignErr, 1);
    chk("mis_busy_low", Busy, 0);
    @(posedge Clock); #1;
    chk("mis_pulse", {Done, AlignErr}, 0);
    chk("mis_reads", rd_q.size() - fb, 0);
    run_load(16'h0001, 2'd2, 1'b1, 1'b0, 0, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
